conv_mem_sched: RTL and testbench

- Top-level sequencer for the shared result-memory port of the convolution pipeline.
- Phase 1: writes the layer0 output stream (conv+ReLU pixels) into the L0 bank.
- Phase 2: performs 2x2/stride-2 max-pooling by reading the L0 bank and writing the L1 bank.
- Sits between layer0 and the external result memory (cwr/crd/csel interface); owns busy/done for the whole job.

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_mem_sched.sv | 183 ++++++++++++++++++
 tb/tb_conv_mem_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution result-memory sequencer.
package conv_pkg;

  localparam int unsigned IMG_LOG2 = 6;
  localparam int unsigned AW       = 2 * IMG_LOG2;
  localparam int unsigned DW       = 20;
  localparam int unsigned L0_DW    = 19;
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned PW       = AW - 2;
  localparam int unsigned NPIX     = 1 << AW;
  localparam int unsigned NPOOL    = 1 << PW;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_L0   = 3'b001;
  localparam logic [2:0] SEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_L0_WR = 3'd1,
    ST_P_RD  = 3'd2,
    ST_P_FIN = 3'd3,
    ST_P_WR  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Unsigned max; on a tie the first (stored) operand wins.
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b > a) ? b : a;
  endfunction

  // L0 address of sub-sample s of pooled pixel p: row 2pr+s[1], col 2pc+s[0].
  function automatic logic [AW-1:0] pool_rd_addr(input logic [PW-1:0] p, input logic [1:0] s);
    return {p[PW-1:PW/2], s[1], p[PW/2-1:0], s[0]};
  endfunction

endpackage

// File: rtl/conv_mem_sched.sv
// Result-memory port sequencer: writes the layer0 stream to L0, then 2x2 max-pools L0 into L1.
module conv_mem_sched
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             l0_valid,
  input  logic [AW-1:0]    l0_addr,
  input  logic [L0_DW-1:0] l0_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cwr,
  output logic [AW-1:0]    caddr_wr,
  output logic [DW-1:0]    cdata_wr,
  output logic             crd,
  output logic [AW-1:0]    caddr_rd,
  input  logic [DW-1:0]    cdata_rd,
  output logic [2:0]       csel
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic [1:0]      s_q, s_d;
  logic [DW-1:0]   max_q, max_d;
  logic            first_q, first_d;
  logic            rd_vld_q, rd_first_q;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            cwr_q, cwr_d, crd_q, crd_d;
  logic [AW-1:0]   caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
  logic [2:0]      csel_q, csel_d;
  logic            l0_ok;

  // Outputs are computed for the cycle the next state occupies, then registered.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    s_d        = s_q;
    max_d      = max_q;
    first_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cwr_d      = 1'b0;
    crd_d      = 1'b0;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    caddr_rd_d = caddr_rd_q;
    csel_d     = SEL_NONE;

    // Read data arrives the cycle after the strobe; first sample of a block loads.
    if (rd_vld_q) begin
      max_d = rd_first_q ? cdata_rd : max2(max_q, cdata_rd);
    end

    l0_ok = (state_q == ST_L0_WR) && (cnt_q != CW'(NPIX));
    if (l0_valid && !l0_ok) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_L0_WR;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          p_d     = '0;
          s_d     = '0;
        end
      end
      ST_L0_WR: begin
        if (cnt_q == CW'(NPIX)) begin
          state_d    = ST_P_RD;
          s_d        = '0;
          crd_d      = 1'b1;
          first_d    = 1'b1;
          csel_d     = SEL_L0;
          caddr_rd_d = pool_rd_addr(p_q, 2'd0);
        end else if (l0_valid) begin
          cwr_d      = 1'b1;
          csel_d     = SEL_L0;
          caddr_wr_d = l0_addr;
          cdata_wr_d = DW'(l0_data);
          cnt_d      = cnt_q + CW'(1);
        end
      end
      ST_P_RD: begin
        if (s_q == 2'd3) begin
          state_d = ST_P_FIN;
        end else begin
          s_d        = s_q + 2'd1;
          crd_d      = 1'b1;
          csel_d     = SEL_L0;
          caddr_rd_d = pool_rd_addr(p_q, s_q + 2'd1);
        end
      end
      ST_P_FIN: begin
        state_d    = ST_P_WR;
        cwr_d      = 1'b1;
        csel_d     = SEL_L1;
        caddr_wr_d = AW'(p_q);
        cdata_wr_d = max_d;
      end
      ST_P_WR: begin
        if (p_q == PW'(NPOOL - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          p_d        = p_q + PW'(1);
          state_d    = ST_P_RD;
          s_d        = '0;
          crd_d      = 1'b1;
          first_d    = 1'b1;
          csel_d     = SEL_L0;
          caddr_rd_d = pool_rd_addr(p_q + PW'(1), 2'd0);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      s_q        <= '0;
      max_q      <= '0;
      first_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      caddr_rd_q <= '0;
      csel_q     <= SEL_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      s_q        <= s_d;
      max_q      <= max_d;
      first_q    <= first_d;
      rd_vld_q   <= crd_q;
      rd_first_q <= first_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cwr_q      <= cwr_d;
      crd_q      <= crd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
      caddr_rd_q <= caddr_rd_d;
      csel_q     <= csel_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cwr      = cwr_q;
  assign crd      = crd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;

endmodule

// File: tb/tb_conv_mem_sched.sv
// Directed bench for conv_mem_sched with a behavioural L0/L1 result memory.
module tb_conv_mem_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        l0_valid;
  logic [11:0] l0_addr;
  logic [18:0] l0_data;
  logic        busy, done, err, cwr, crd;
  logic [11:0] caddr_wr, caddr_rd;
  logic [19:0] cdata_wr;
  logic [19:0] cdata_rd = 20'd0;
  logic [2:0]  csel;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [19:0] l0_mem [4096];
  logic [19:0] l1_mem [1024];
  bit          use_ovr = 1'b0;

  conv_mem_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .l0_valid (l0_valid),
    .l0_addr  (l0_addr),
    .l0_data  (l0_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel)
  );

  always #5 clk = ~clk;

  // Pool block 0 gets directed values, block 1 is forced to zero.
  function automatic logic [19:0] ovr_val(input logic [11:0] a, input logic [19:0] m);
    case (a)
      12'd0:  return 20'h00005;
      12'd1:  return 20'hFFFFF;
      12'd64: return 20'h00007;
      12'd65: return 20'hFFFFF;
      12'd2, 12'd3, 12'd66, 12'd67: return 20'h00000;
      default: return m;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cwr && csel == 3'b001) l0_mem[caddr_wr] <= cdata_wr;
    if (cwr && csel == 3'b011) l1_mem[caddr_wr[9:0]] <= cdata_wr;
    if (crd) cdata_rd <= use_ovr ? ovr_val(caddr_rd, l0_mem[caddr_rd]) : l0_mem[caddr_rd];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Streams 4096 raster pixels back-to-back and checks each write one cycle later.
  task automatic stream(input bit raster);
    logic [11:0] pa;
    logic [19:0] pd;
    logic        wr_ok;
    pa = '0; pd = '0; wr_ok = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk); #1;
      l0_valid = 1'b1;
      l0_addr  = 12'(i);
      l0_data  = raster ? 19'(i) : 19'd0;
      if (i > 0) begin
        @(negedge clk);
        if ({crd, cwr, csel, caddr_wr, cdata_wr} !== {1'b0, 1'b1, 3'b001, pa, pd}) wr_ok = 1'b0;
        if (i == 1) chk("l0_wr_first", 64'({cwr, csel, caddr_wr, cdata_wr}), 64'({1'b1, 3'b001, pa, pd}));
      end
      pa = 12'(i);
      pd = raster ? 20'(i) : 20'd0;
    end
    chk("l0_wr_stream", 64'(wr_ok), 64'(1));
    @(posedge clk); #1 l0_valid = 1'b0;
    @(negedge clk);
    chk("l0_wr_last", 64'({crd, cwr, csel, caddr_wr, cdata_wr}), 64'({1'b0, 1'b1, 3'b001, pa, pd}));
    @(negedge clk);
    chk("p_rd_first", 64'({cwr, crd, csel, caddr_rd}), 64'({1'b0, 1'b1, 3'b001, 12'd0}));
  endtask

  // Called at the negedge of the first P_RD cycle; runs to done and past it.
  task automatic pool(input bit inj);
    int unsigned n, dn;
    bit prev_busy, seen_done, excl_ok, busy_any;
    n = 0; dn = 0; seen_done = 1'b0; excl_ok = 1'b1; busy_any = 1'b0;
    prev_busy = busy;
    while (n < 7000 && !seen_done) begin
      @(negedge clk);
      n++;
      if (n == 8) start = 1'b1;
      if (n == 9) start = 1'b0;
      if (inj && n == 20) begin
        l0_valid = 1'b1; l0_addr = 12'd200; l0_data = 19'h00123;
      end
      if (inj && n == 21) begin
        chk("err_set", 64'(err), 64'(1));
        l0_valid = 1'b0;
      end
      if (cwr && crd) excl_ok = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        chk("busy_falls_with_done", 64'({busy, prev_busy}), 64'(2'b01));
        chk("csel_idle_at_done", 64'(csel), 64'(3'b000));
        if (inj) chk("err_held", 64'(err), 64'(1));
      end else begin
        prev_busy = busy;
      end
    end
    chk("done_latency", 64'(n), 64'(6144));
    chk("strobe_exclusive", 64'(excl_ok), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done) dn++;
      if (busy) busy_any = 1'b1;
      @(negedge clk);
    end
    chk("single_done", 64'(dn), 64'(0));
    chk("start_in_done_ignored", 64'(busy_any), 64'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; l0_valid = 1'b0; l0_addr = '0; l0_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vals", 64'({busy, done, err, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr}), 64'(0));
    reset = 1'b0;

    // Abort a job after 100 pixels with an asynchronous reset.
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      l0_valid = 1'b1; l0_addr = 12'(i + 7); l0_data = 19'(i + 7);
    end
    @(negedge clk);
    chk("busy_mid_l0", 64'({busy, cwr, csel}), 64'({1'b1, 1'b1, 3'b001}));
    #2 reset = 1'b1;
    #1 l0_valid = 1'b0;
    #1;
    chk("reset_mid_job", 64'({busy, done, err, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", 64'({busy, cwr, crd}), 64'(0));

    // Full raster job: L0 = addr, so each pooled value is the bottom-right sample.
    pulse_start();
    @(negedge clk);
    chk("busy_after_start", 64'({busy, err}), 64'(2'b10));
    stream(1'b1);
    pool(1'b0);
    chk("l1_0", 64'(l1_mem[0]), 64'(65));
    chk("l1_32", 64'(l1_mem[32]), 64'(193));
    chk("l1_33", 64'(l1_mem[33]), 64'(195));
    chk("l1_1023", 64'(l1_mem[1023]), 64'(4095));

    // Directed block values, stray l0_valid during pooling.
    use_ovr = 1'b1;
    pulse_start();
    stream(1'b0);
    pool(1'b1);
    chk("l1_max_tie", 64'(l1_mem[0]), 64'(20'hFFFFF));
    chk("l1_all_zero", 64'(l1_mem[1]), 64'(0));
    chk("no_stray_write", 64'(l0_mem[200]), 64'(0));
    chk("err_sticky_idle", 64'(err), 64'(1));

    pulse_start();
    @(negedge clk);
    chk("err_cleared_by_start", 64'({busy, err}), 64'(2'b10));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
